// File: rtl/sync_fifo_pkg.sv
//==============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and pointer/count width helpers for the
//               parametrised synchronous FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AF_MARGIN = 2;
    localparam int DEF_AE_MARGIN = 2;

    // Address width of the storage array; never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy spans 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem_2p.sv
//==============================================================================
// Module      : fifo_mem_2p
// Description : DEPTH x DATA_W register array, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
//==============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty and sticky error flags.
//               Define SYNC_FIFO_FWFT_EN for first-word fall-through output;
//               default is a registered read with one cycle latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_MARGIN = DEF_AE_MARGIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almostfull,
    output logic                     almostempty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_ptr_w = ptr_w(DEPTH);
    localparam int c_cnt_w = cnt_w(DEPTH);

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full_lvl = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_lvl   = c_cnt_w'(DEPTH - AF_MARGIN);
    localparam logic [c_cnt_w-1:0] c_ae_lvl   = c_cnt_w'(AE_MARGIN);

    logic [c_ptr_w-1:0] w_ptr_q, w_ptr_d;
    logic [c_ptr_w-1:0] r_ptr_q, r_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wr_acc, rd_acc;
    logic [DATA_W-1:0]  mem_rdata;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (w_ptr_q),
        .wr_data (data_in),
        .rd_addr (r_ptr_q),
        .rd_data (mem_rdata)
    );

    // Every status output decodes the registered count only.
    assign full        = (count_q == c_full_lvl);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= c_af_lvl);
    assign almostempty = (count_q <= c_ae_lvl);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_comb begin
        wr_acc  = w_en && !full;
        rd_acc  = r_en && !empty;
        w_ptr_d = wr_acc ? (w_ptr_q + c_ptr_one) : w_ptr_q;
        r_ptr_d = rd_acc ? (r_ptr_q + c_ptr_one) : r_ptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        // A fresh error on the clearing edge keeps the flag set.
        overflow_d  = (w_en && full)  || (overflow_q  && !err_clr);
        underflow_d = (r_en && empty) || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown while occupied; no bypass from the write port.
    assign data_out = empty ? '0 : mem_rdata;
`else
    logic [DATA_W-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = rd_acc ? mem_rdata : data_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
//==============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench for sync_fifo_param (8x8,
//               margins 2/2); follows SYNC_FIFO_FWFT_EN like the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, almostfull, almostempty;
    logic [3:0] count;
    logic       overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    logic [7:0] last_pop = 8'h00;
    logic [7:0] words[8] = '{8'h03, 8'h09, 8'h07, 8'h15, 8'h2A, 8'h3C, 8'h44, 8'h5F};

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_MARGIN (2),
        .AE_MARGIN (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w_en        (w_en),
        .r_en        (r_en),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        w_en    = 1'b1;
        data_in = d;
        tick();
        w_en    = 1'b0;
        mq.push_back(d);
    endtask

    task automatic pop();
        logic [7:0] exp;
        exp = mq.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_head", data_out, exp);
`endif
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check("rd_data", data_out, exp);
`endif
        last_pop = exp;
    endtask

    task automatic check_idle_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almostempty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almostfull, 0);
        check("rst_dout", data_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_reset();

        // Error and traffic, then asynchronous reset mid-stream
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("udf_first", underflow, 1);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        pop();
        reset = 1'b0;
        mq.delete();
        tick();
        check_idle_reset();
        reset = 1'b1;
        tick();

        // Fill with threshold tracking
        for (int i = 0; i < 8; i++) begin
            push(words[i]);
            check("fill_count", count, i + 1);
            check("fill_aempty", almostempty, (i + 1) <= 2);
            check("fill_afull", almostfull, (i + 1) >= 6);
            check("fill_full", full, (i + 1) == 8);
        end
        w_en    = 1'b1;
        data_in = 8'hEE;
        tick();
        w_en    = 1'b0;
        check("ovf_count", count, 8);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            pop();
            check("drain_count", count, 7 - i);
        end
        check("drain_empty", empty, 1);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("udf_flag", underflow, 1);
        check("udf_count", count, 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("udf_dout", data_out, 8'h00);
`else
        check("udf_dout", data_out, 8'h5F);
`endif
        check("ovf_sticky", overflow, 1);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_udf", underflow, 0);

        // Pointer wrap across index 7 -> 0
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        check("wrap_count", count, 6);
        for (int i = 0; i < 6; i++) pop();
        check("wrap_empty", empty, 1);

        // Simultaneous read/write at count 4
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp;
            exp = mq.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
            check("rw_head", data_out, exp);
`endif
            w_en    = 1'b1;
            r_en    = 1'b1;
            data_in = 8'hB0 + 8'(i);
            tick();
            mq.push_back(data_in);
`ifndef SYNC_FIFO_FWFT_EN
            check("rw_data", data_out, exp);
`endif
            check("rw_count", count, 4);
        end
        w_en = 1'b0;
        r_en = 1'b0;
        for (int i = 0; i < 4; i++) pop();

        // Simultaneous at full: read wins, write rejected
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        begin
            logic [7:0] exp;
            exp = mq.pop_front();
            w_en    = 1'b1;
            r_en    = 1'b1;
            data_in = 8'hDD;
            tick();
            w_en    = 1'b0;
            r_en    = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
            check("rwf_dout", data_out, 8'hC1);
`else
            check("rwf_dout", data_out, exp);
`endif
            check("rwf_count", count, 7);
            check("rwf_ovf", overflow, 1);
        end
        for (int i = 0; i < 7; i++) pop();

        // Simultaneous at empty: write wins, read rejected
        w_en    = 1'b1;
        r_en    = 1'b1;
        data_in = 8'hE5;
        tick();
        w_en    = 1'b0;
        r_en    = 1'b0;
        mq.push_back(8'hE5);
        check("rwe_count", count, 1);
        check("rwe_udf", underflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("rwe_dout", data_out, 8'hE5);
`else
        check("rwe_dout", data_out, 8'hC7);
`endif

        // Clear, then clear colliding with a rejected write
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr2_ovf", overflow, 0);
        check("clr2_udf", underflow, 0);
        for (int i = 0; i < 7; i++) push(8'hF0 + 8'(i));
        check("refill_full", full, 1);
        w_en    = 1'b1;
        err_clr = 1'b1;
        data_in = 8'h77;
        tick();
        w_en    = 1'b0;
        check("clrhit_ovf", overflow, 1);
        check("clrhit_count", count, 8);
        tick();
        err_clr = 1'b0;
        check("clr3_ovf", overflow, 0);
        pop();
        check("tail_count", count, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
